// File: rtl/bus2to1_arb_pkg.sv
`default_nettype none
// ============================================================================
// bus2to1_arb_pkg : shared native-bus widths, arbiter state codes, error data
// Revision: 1.0
// ============================================================================
package bus2to1_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t OWN_M1 = 2'd1;
    localparam arb_state_t OWN_M2 = 2'd2;

    // Identity of the master that completed most recently (round-robin memory).
    localparam logic MST_M1 = 1'b0;
    localparam logic MST_M2 = 1'b1;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == OWN_M1) g = 2'b01;
        if (s == OWN_M2) g = 2'b10;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
// bus_timeout_cnt : saturating wait counter with clear/enable and expiry flag
// Revision: 1.0
// ============================================================================
module bus_timeout_cnt #(
    parameter int unsigned LIMIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned        CNT_W   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   LAST    = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;
    localparam logic               ENABLED = (LIMIT > 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged while still waiting, so the caller can abort in the same cycle.
    assign expire_o = ENABLED && en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/bus2to1_arb.sv
`default_nettype none
// ============================================================================
// bus2to1_arb : two-master / one-slave arbiter for the valid/ready native bus
// Revision: 1.0
// ============================================================================
module bus2to1_arb
    import bus2to1_arb_pkg::*;
#(
    parameter int unsigned       PRIORITY       = 0,
    parameter int unsigned       TIMEOUT_CYCLES = 0,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m1valid,
    output logic              m1ready,
    input  logic [ADDR_W-1:0] m1addr,
    output logic [DATA_W-1:0] m1rdata,
    input  logic [DATA_W-1:0] m1wdata,
    input  logic [STRB_W-1:0] m1wstrb,

    input  logic              m2valid,
    output logic              m2ready,
    input  logic [ADDR_W-1:0] m2addr,
    output logic [DATA_W-1:0] m2rdata,
    input  logic [DATA_W-1:0] m2wdata,
    input  logic [STRB_W-1:0] m2wstrb,

    output logic              svalid,
    input  logic              sready,
    output logic [ADDR_W-1:0] saddr,
    input  logic [DATA_W-1:0] srdata,
    output logic [DATA_W-1:0] swdata,
    output logic [STRB_W-1:0] swstrb,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              last_q;
    logic              last_d;

    logic              owner_valid;
    logic              done_ok;
    logic              expire;
    logic              done;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        owner_valid = 1'b0;
        case (state_q)
            OWN_M1:  owner_valid = m1valid;
            OWN_M2:  owner_valid = m2valid;
            default: owner_valid = 1'b0;
        endcase
    end

    assign done_ok   = owner_valid && sready;
    assign done      = done_ok || expire;
    assign resp_data = done_ok ? srdata : ERR_DATA;

    // Counter only runs while the owner is actively waiting; any exit clears it.
    bus_timeout_cnt #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (resetn),
        .clr_i    (!owner_valid || done),
        .en_i     (owner_valid && !sready),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= MST_M2;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m1valid && m2valid) begin
                    state_d = ((PRIORITY != 0) || (last_q == MST_M2)) ? OWN_M1 : OWN_M2;
                end else if (m1valid) begin
                    state_d = OWN_M1;
                end else if (m2valid) begin
                    state_d = OWN_M2;
                end
            end
            OWN_M1: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = MST_M1;
                end else if (!m1valid) begin
                    state_d = IDLE;
                end
            end
            OWN_M2: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = MST_M2;
                end else if (!m2valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        svalid      = 1'b0;
        saddr       = '0;
        swdata      = '0;
        swstrb      = '0;
        m1ready     = 1'b0;
        m1rdata     = '0;
        m2ready     = 1'b0;
        m2rdata     = '0;
        timeout_err = expire;
        case (state_q)
            OWN_M1: begin
                svalid  = m1valid;
                saddr   = m1addr;
                swdata  = m1wdata;
                swstrb  = m1wstrb;
                m1ready = done;
                m1rdata = done ? resp_data : '0;
            end
            OWN_M2: begin
                svalid  = m2valid;
                saddr   = m2addr;
                swdata  = m2wdata;
                swstrb  = m2wstrb;
                m2ready = done;
                m2rdata = done ? resp_data : '0;
            end
            default: ;
        endcase
    end

    assign grant = grant_of(state_q);

endmodule
`default_nettype wire

// File: tb/tb_bus2to1_arb.sv
`default_nettype none
// ============================================================================
// tb_bus2to1_arb : directed vector table, corner sequences, random vs model
// Revision: 1.0
// ============================================================================
module tb_bus2to1_arb;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam logic [31:0] A1  = 32'h0000_0010;
    localparam logic [31:0] A2  = 32'h1000_0000;
    localparam logic [31:0] WD2 = 32'h0000_0041;
    localparam logic [3:0]  WS2 = 4'b0001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m1valid, m2valid, sready;
    logic [31:0] m1addr, m1wdata, m2addr, m2wdata, srdata;
    logic [3:0]  m1wstrb, m2wstrb;

    logic        m1ready, m2ready, svalid, timeout_err;
    logic [31:0] m1rdata, m2rdata, saddr, swdata;
    logic [3:0]  swstrb;
    logic [1:0]  grant;

    logic        p_m1ready, p_m2ready, p_svalid, p_timeout_err;
    logic [31:0] p_m1rdata, p_m2rdata, p_saddr, p_swdata;
    logic [3:0]  p_swstrb;
    logic [1:0]  p_grant;

    logic [137:0] obs, p_obs;
    assign obs   = {svalid, grant, m1ready, m2ready, timeout_err,
                    m1rdata, m2rdata, saddr, swdata, swstrb};
    assign p_obs = {p_svalid, p_grant, p_m1ready, p_m2ready, p_timeout_err,
                    p_m1rdata, p_m2rdata, p_saddr, p_swdata, p_swstrb};

    always #5 clk = ~clk;

    bus2to1_arb #(.PRIORITY(0), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m1valid(m1valid), .m1ready(m1ready), .m1addr(m1addr), .m1rdata(m1rdata),
        .m1wdata(m1wdata), .m1wstrb(m1wstrb),
        .m2valid(m2valid), .m2ready(m2ready), .m2addr(m2addr), .m2rdata(m2rdata),
        .m2wdata(m2wdata), .m2wstrb(m2wstrb),
        .svalid(svalid), .sready(sready), .saddr(saddr), .srdata(srdata),
        .swdata(swdata), .swstrb(swstrb), .grant(grant), .timeout_err(timeout_err)
    );

    bus2to1_arb #(.PRIORITY(1), .TIMEOUT_CYCLES(0), .ERR_DATA(ERR)) dut_p (
        .clk(clk), .resetn(resetn),
        .m1valid(m1valid), .m1ready(p_m1ready), .m1addr(m1addr), .m1rdata(p_m1rdata),
        .m1wdata(m1wdata), .m1wstrb(m1wstrb),
        .m2valid(m2valid), .m2ready(p_m2ready), .m2addr(m2addr), .m2rdata(p_m2rdata),
        .m2wdata(m2wdata), .m2wstrb(m2wstrb),
        .svalid(p_svalid), .sready(sready), .saddr(p_saddr), .srdata(srdata),
        .swdata(p_swdata), .swstrb(p_swstrb), .grant(p_grant), .timeout_err(p_timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v1, v2, sr;
        logic [31:0] srd;
        logic        esv;
        logic [1:0]  egr;
        logic        er1, er2;
        logic [31:0] erd;
        logic        eto;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v1, input logic v2, input logic sr,
                                input logic [31:0] srd, input logic esv, input logic [1:0] egr,
                                input logic er1, input logic er2, input logic [31:0] erd,
                                input logic eto);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.sr = sr; v.srd = srd; v.esv = esv; v.egr = egr;
        v.er1 = er1; v.er2 = er2; v.erd = erd; v.eto = eto;
        return v;
    endfunction

    function automatic logic [137:0] pack_exp(input logic sv, input logic [1:0] gr,
                                              input logic r1, input logic r2, input logic to,
                                              input logic [31:0] rd, input logic [31:0] sa,
                                              input logic [31:0] wd, input logic [3:0] ws);
        return {sv, gr, r1, r2, to, (r1 ? rd : 32'h0), (r2 ? rd : 32'h0), sa, wd, ws};
    endfunction

    task automatic idle_inputs();
        m1valid = 1'b0; m2valid = 1'b0; sready = 1'b0; srdata = 32'h0;
        m1addr = A1; m1wdata = 32'h0; m1wstrb = 4'h0;
        m2addr = A2; m2wdata = WD2;   m2wstrb = WS2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #1;
        check("reset_state", obs, 138'h0);
        check("reset_state_p", p_obs, 138'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] sa, wd;
        logic [3:0]  ws;
        logic [1:0]  eg, egp;
        int          owner, last, waited;
        bit          act1, act2, ov, fin, er1, er2, eto;
        logic [31:0] erd;

        idle_inputs();

        // M1 read, then sready while idle
        tbl.push_back(mk(1,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,          1,2'b01,0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,          1,2'b01,0,0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'h1234_5678,  1,2'b01,1,0,32'h1234_5678,0));
        tbl.push_back(mk(0,0,1,32'hFFFF_0000,  0,2'b00,0,0,32'h0,0));
        // M2 write
        tbl.push_back(mk(0,1,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,32'h0,          1,2'b10,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,32'hCAFE_0001,  1,2'b10,0,1,32'hCAFE_0001,0));
        tbl.push_back(mk(0,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        // M1 timeout, then M2 served normally
        tbl.push_back(mk(1,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        for (int k = 0; k < TO - 1; k++) tbl.push_back(mk(1,0,0,32'h0, 1,2'b01,0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,32'h0,          1,2'b01,1,0,ERR,1));
        tbl.push_back(mk(0,1,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(0,1,1,32'h0000_55AA,  1,2'b10,0,1,32'h0000_55AA,0));
        tbl.push_back(mk(0,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        // sready on the expiry cycle wins
        tbl.push_back(mk(1,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        for (int k = 0; k < TO - 1; k++) tbl.push_back(mk(1,0,0,32'h0, 1,2'b01,0,0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'h0BAD_F00D,  1,2'b01,1,0,32'h0BAD_F00D,0));
        tbl.push_back(mk(0,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        // M2 drops valid early: no ready, last stays M1, so the next tie goes to M2
        tbl.push_back(mk(0,1,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,32'h0,          1,2'b10,0,0,32'h0,0));
        tbl.push_back(mk(0,0,1,32'h0000_0077,  0,2'b10,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(1,1,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(1,1,1,32'h0000_1111,  1,2'b10,0,1,32'h0000_1111,0));
        tbl.push_back(mk(1,0,0,32'h0,          0,2'b00,0,0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'h0000_2222,  1,2'b01,1,0,32'h0000_2222,0));
        tbl.push_back(mk(0,0,0,32'h0,          0,2'b00,0,0,32'h0,0));

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            m1valid = tbl[i].v1; m2valid = tbl[i].v2;
            sready  = tbl[i].sr; srdata  = tbl[i].srd;
            #1;
            sa = (tbl[i].egr == 2'b01) ? A1 : (tbl[i].egr == 2'b10) ? A2  : 32'h0;
            wd = (tbl[i].egr == 2'b10) ? WD2 : 32'h0;
            ws = (tbl[i].egr == 2'b10) ? WS2 : 4'h0;
            check($sformatf("vec%0d", i), obs,
                  pack_exp(tbl[i].esv, tbl[i].egr, tbl[i].er1, tbl[i].er2, tbl[i].eto,
                           tbl[i].erd, sa, wd, ws));
        end

        // Continuous contention: round-robin alternates, fixed priority starves M2
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m1valid = 1'b1; m2valid = 1'b1; sready = 1'b1; srdata = 32'h0000_0100 + c;
            #1;
            eg  = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
            egp = (c % 2 == 0) ? 2'b00 : 2'b01;
            check($sformatf("rr_grant%0d", c), grant, eg);
            check($sformatf("prio_grant%0d", c), p_grant, egp);
        end

        // Asynchronous reset while M2 owns the bus
        do_reset();
        @(negedge clk);
        m2valid = 1'b1;
        #1;
        @(negedge clk);
        sready = 1'b1; srdata = 32'h0000_ABCD;
        #1;
        check("pre_reset", {svalid, grant, m2ready}, {1'b1, 2'b10, 1'b1});
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset", {svalid, grant, m2ready, m2rdata}, 36'h0);
        @(negedge clk);
        resetn = 1'b1; m1valid = 1'b1; m2valid = 1'b1; sready = 1'b0;
        #1;
        check("post_reset_idle", grant, 2'b00);
        @(negedge clk);
        #1;
        check("post_reset_tie", grant, 2'b01);

        // Randomised traffic against the reference model
        do_reset();
        owner = 0; last = 2; waited = 0; act1 = 1'b0; act2 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!act1) begin
                m1addr = $urandom; m1wdata = $urandom; m1wstrb = 4'($urandom);
                act1 = ($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 31) == 0) begin
                act1 = 1'b0;
            end
            if (!act2) begin
                m2addr = $urandom; m2wdata = $urandom; m2wstrb = 4'($urandom);
                act2 = ($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 31) == 0) begin
                act2 = 1'b0;
            end
            m1valid = act1; m2valid = act2;
            sready  = ($urandom_range(0, 3) == 0);
            srdata  = $urandom;
            #1;
            ov  = (owner == 1) ? m1valid : (owner == 2) ? m2valid : 1'b0;
            eg  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            sa  = (owner == 1) ? m1addr  : (owner == 2) ? m2addr  : 32'h0;
            wd  = (owner == 1) ? m1wdata : (owner == 2) ? m2wdata : 32'h0;
            ws  = (owner == 1) ? m1wstrb : (owner == 2) ? m2wstrb : 4'h0;
            fin = 1'b0; eto = 1'b0; erd = 32'h0;
            if (ov && sready) begin
                fin = 1'b1; erd = srdata;
            end else if (ov && waited == TO - 1) begin
                fin = 1'b1; erd = ERR; eto = 1'b1;
            end
            er1 = fin && (owner == 1);
            er2 = fin && (owner == 2);
            check($sformatf("rand%0d", cyc), obs, pack_exp(ov, eg, er1, er2, eto, erd, sa, wd, ws));
            if (owner != 0) begin
                if (fin) begin
                    last = owner; owner = 0; waited = 0;
                end else if (!ov) begin
                    owner = 0; waited = 0;
                end else begin
                    waited++;
                end
            end else if (m1valid && m2valid) begin
                owner = (last == 1) ? 2 : 1;
            end else if (m1valid) begin
                owner = 1;
            end else if (m2valid) begin
                owner = 2;
            end
            if (er1) act1 = 1'b0;
            if (er2) act2 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus2to1_arb.md
Name: bus2to1_arb

Overview:
- Two-master, one-slave arbiter for the valid/ready/addr/rdata/wdata/wstrb native bus.
- Lets a second requester (e.g. a DMA or debug master) share the memory/peripheral path with vigna_top.
- Sits between the masters and the bus1to2 decoder, or directly in front of mem_sim.
- Serialises requests, holds the grant for the whole transaction, and recovers from a silent slave with a timeout.

Parameters:
- PRIORITY, 0, 0 = round-robin between M1/M2; 1 = M1 fixed priority.
- TIMEOUT_CYCLES, 0, max cycles a granted transaction may wait for sready; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned to the master on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m1valid  in  1  M1 request; held high until m1ready.
- m1ready  out  1  M1 completion pulse.
- m1addr  in  32  M1 address.
- m1rdata  out  32  M1 read data, valid with m1ready.
- m1wdata  in  32  M1 write data.
- m1wstrb  in  4  M1 byte strobes; 0 = read.
- m2valid, m2ready, m2addr, m2rdata, m2wdata, m2wstrb: same widths and meaning, for M2.
- svalid  out  1  slave request.
- sready  in  1  slave completion.
- saddr  out  32  slave address.
- srdata  in  32  slave read data.
- swdata  out  32  slave write data.
- swstrb  out  4  slave strobes.
- grant  out  2  one-hot current owner: bit0 = M1, bit1 = M2.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted by timeout.

Behaviour:
- Reset: resetn low asynchronously forces
  - state = IDLE, grant = 0, last = M2 (so M1 wins the first tie), timeout counter = 0;
  - svalid = 0, saddr/swdata/swstrb = 0, m1ready = m2ready = 0, m1rdata = m2rdata = 0, timeout_err = 0.
- FSM states: IDLE, OWN_M1, OWN_M2; the grant register is state-encoded.
- IDLE:
  - Only m1valid -> OWN_M1 next edge.
  - Only m2valid -> OWN_M2 next edge.
  - Both valid: PRIORITY=1 -> M1; PRIORITY=0 -> the master that is not `last`.
  - Arbitration latency is one cycle: svalid is first asserted the cycle after the request is seen.
- OWN_Mx:
  - svalid = mxvalid; saddr/swdata/swstrb = Mx signals (combinational mux).
  - Non-owner outputs: ready = 0, rdata = 0.
- Completion: when svalid && sready in OWN_Mx:
  - mxready = 1 and mxrdata = srdata in the same cycle (combinational);
  - next state = IDLE, last <= Mx, counter <= 0.
- Back-to-back transactions:
  - A master that keeps valid high re-arbitrates from IDLE, so each transaction takes at least 2 cycles at the arbiter.
  - Round-robin therefore alternates when both masters are continuously requesting.
- Protocol violation: owner drops mxvalid before ready -> svalid drops immediately, next state = IDLE, `last` is not updated, and no ready is issued.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each OWN cycle without sready.
  - When it reaches TIMEOUT_CYCLES-1 without sready:
    - mxready = 1, mxrdata = ERR_DATA, timeout_err = 1 that cycle;
    - svalid is still asserted that cycle;
    - next state = IDLE, last <= Mx.
  - sready in the expiry cycle wins: normal completion, no error.
  - Counter width = $clog2(TIMEOUT_CYCLES+1), saturating; never wraps.
- sready while in IDLE is ignored; no ready is forwarded to either master.
- Reset asserted mid-transaction: all outputs drop asynchronously and the transaction is lost. Masters must re-request after reset.
- mxready is never asserted to both masters in the same cycle; grant is never 2'b11.

Decomposition:
- Shared bus package holds:
  - state localparams: IDLE = 2'd0, OWN_M1 = 2'd1, OWN_M2 = 2'd2;
  - bus width constants: ADDR_W = 32, DATA_W = 32, STRB_W = 4;
  - the default ERR_DATA constant, reused by future bus timeout logic.
- One sub-module: bus_timeout_cnt (parameterised saturating counter with clear/enable/expire). It is reusable in bus1to2 later.
- Arbitration and muxing stay in bus2to1_arb.

Test Plan:
1. M1 read alone, addr 32'h0000_0010, slave ready 2 cycles after svalid with srdata 32'h1234_5678 -> svalid rises 1 cycle after m1valid; m1ready=1 with m1rdata=32'h1234_5678; grant=01 throughout; m2ready stays 0.
2. M1 and M2 request in the same cycle with PRIORITY=0, continuously, 4 transactions -> grant order M1, M2, M1, M2. With PRIORITY=1 -> M1 four times while M2 waits.
3. M2 write, addr 32'h1000_0000, wdata 32'h0000_0041, wstrb 4'b0001 -> saddr/swdata/swstrb match exactly while svalid; one m2ready pulse; m1 outputs zero.
4. TIMEOUT_CYCLES=8, slave never ready on an M1 read -> on the 8th OWN cycle m1ready=1, m1rdata=32'hDEAD_BEEF, timeout_err=1 for 1 cycle; FSM is back in IDLE; the next M2 request is served normally.
5. sready arrives exactly on the expiry cycle -> normal rdata returned, timeout_err stays 0.
6. resetn pulled low while OWN_M2 with svalid high -> svalid, grant, m2ready drop without waiting for a clock; after release the first tie goes to M1.
